// File: rtl/sysid_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sysid_read_arbiter
// Description : Two-master read arbiter in front of a combinational system-ID
//               slave; round-robin or fixed priority, one read per 3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================

module sysid_read_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_read,
    input  logic        m0_address,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,

    input  logic        m1_read,
    input  logic        m1_address,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,

    output logic        s_address,
    input  logic [31:0] s_readdata,

    output logic        busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic c_M0 = 1'b0;
    localparam logic c_M1 = 1'b1;

    logic [1:0]  state_q,      state_d;
    logic        grant_q,      grant_d;
    logic        last_grant_q, last_grant_d;
    logic        s_address_q,  s_address_d;
    logic [31:0] m0_rdata_q,   m0_rdata_d;
    logic [31:0] m1_rdata_q,   m1_rdata_d;

    logic        w_any_req;
    logic        w_winner;
    logic        w_grant_read;

    // Arbitration: a lone requester always wins; a tie goes to the master
    // not served last in round-robin mode, otherwise to master 0.
    always_comb begin
        w_any_req = m0_read | m1_read;
        if (m0_read && m1_read) begin
            w_winner = (RR_ENABLE != 0) ? ~last_grant_q : c_M0;
        end else begin
            w_winner = m1_read ? c_M1 : c_M0;
        end
        w_grant_read = (grant_q == c_M1) ? m1_read : m0_read;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_any_req) begin
                    state_d = c_ACCESS;
                end
            end
            c_ACCESS: begin
                // A master that dropped its read before acceptance is abandoned.
                state_d = w_grant_read ? c_RESP : c_IDLE;
            end
            c_RESP: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (reset masks handshake outputs in the same cycle)
    // ------------------------------------------------------------------
    always_comb begin
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        busy             = (state_q != c_IDLE);

        if (!reset) begin
            if (state_q == c_ACCESS) begin
                if (grant_q == c_M0) begin
                    m0_waitrequest = ~m0_read;
                end else begin
                    m1_waitrequest = ~m1_read;
                end
            end
            if (state_q == c_RESP) begin
                if (grant_q == c_M0) begin
                    m0_readdatavalid = 1'b1;
                end else begin
                    m1_readdatavalid = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant, slave address and read-data capture
    // ------------------------------------------------------------------
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_address_d  = s_address_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        case (state_q)
            c_IDLE: begin
                if (w_any_req) begin
                    grant_d     = w_winner;
                    s_address_d = (w_winner == c_M1) ? m1_address : m0_address;
                end
            end
            c_ACCESS: begin
                if (w_grant_read) begin
                    if (grant_q == c_M0) begin
                        m0_rdata_d = s_readdata;
                    end else begin
                        m1_rdata_d = s_readdata;
                    end
                end
            end
            c_RESP: begin
                last_grant_d = grant_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q      <= c_M0;
            last_grant_q <= c_M1;
            s_address_q  <= 1'b0;
            m0_rdata_q   <= 32'h0000_0000;
            m1_rdata_q   <= 32'h0000_0000;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_address_q  <= s_address_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign s_address   = s_address_q;
    assign m0_readdata = m0_rdata_q;
    assign m1_readdata = m1_rdata_q;

endmodule

`default_nettype wire

// File: doc/sysid_read_arbiter.md
SYSID_READ_ARBITER -- requirements
Module: sysid_read_arbiter

Interface
REQ-001 Parameter: RR_ENABLE, default 1, 1 = round-robin arbitration, 0 = fixed priority with master 0 always winning.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 m0_read  in  1  master 0 read request; held until accepted.
REQ-005 m0_address  in  1  master 0 word address.
REQ-006 m0_waitrequest  out  1  low for exactly one cycle when master 0's read is accepted.
REQ-007 m0_readdata  out  32  registered read data for master 0.
REQ-008 m0_readdatavalid  out  1  one-cycle pulse qualifying m0_readdata.
REQ-009 m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: same directions, widths and meaning as REQ-004..008, for master 1.
REQ-010 s_address  out  1  registered address driven to the shared ID slave.
REQ-011 s_readdata  in  32  combinational read data returned by the ID slave.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-014 IDLE, no mx_read asserted: stay in IDLE.
REQ-015 IDLE, at least one mx_read asserted: select a winner, register s_address from the winner's address, store the grant, and go to ACCESS.
REQ-016 Round-robin mode (RR_ENABLE=1), both requesting: the master not granted last SHALL win; a single requester always wins.
REQ-017 Fixed-priority mode (RR_ENABLE=0): master 0 SHALL win whenever it requests.
REQ-018 ACCESS with the granted mx_read still high: drive the granted mx_waitrequest low, capture s_readdata into the granted mx_readdata, and go to RESP.
REQ-019 ACCESS with the granted mx_read low (master violated the hold rule): abort, return to IDLE, keep waitrequest high, produce no readdatavalid, and leave last-grant unchanged.
REQ-020 RESP: pulse the granted mx_readdatavalid for one cycle, update last-grant to the granted master, and return to IDLE.
REQ-021 The non-granted master's waitrequest SHALL stay high throughout, and its readdata SHALL be unchanged.
REQ-022 mx_waitrequest SHALL be high in every cycle except the ACCESS cycle of its own grant.
REQ-023 Latency: read first sampled high in IDLE at cycle T, waitrequest low at T+1, readdatavalid at T+2; one transaction per 3 cycles at most.
REQ-024 A request arriving while busy SHALL be held off by waitrequest and arbitrated at the next IDLE cycle.
REQ-025 Read data SHALL be passed through unmodified, full 32 bits, with no sign or width change.
REQ-026 mx_readdata SHALL hold its last captured value until that master's next accepted read.

Reset
REQ-027 On reset high at a rising edge: state=IDLE, both waitrequest=1, both readdatavalid=0, both readdata=0, s_address=0, busy=0, last-grant=master 1 (so master 0 wins the first tie).
REQ-028 Reset asserted in ACCESS or RESP SHALL abort the transaction with no readdatavalid, taking priority over every other transition.

Verification
REQ-029 Slave model returns 0x00000000 at address 0 and 0x5E426C44 at address 1; m0 reads address 1 at T -> m0_waitrequest low at T+1, m0_readdatavalid=1 with m0_readdata=0x5E426C44 at T+2.
REQ-030 m0 and m1 both request at T after reset (RR_ENABLE=1) -> m0 served (valid at T+2); m1 waitrequest low at T+4, valid at T+5; m1 then re-requests alongside m0 -> m1 yields to m0.
REQ-031 RR_ENABLE=0, both requesting continuously -> m0 granted every transaction and m1_waitrequest stays high.
REQ-032 m1 granted, then drops m1_read in ACCESS -> FSM back in IDLE next cycle, no m1_readdatavalid, m1_readdata unchanged.
REQ-033 Reset pulsed during RESP -> no readdatavalid that cycle; all outputs at reset values on the next cycle; the next tie goes to m0.
